// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// controller state type and the default datapath width.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Operation select. Bit 1 picks divide and bit 0 picks unsigned.
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_FINISH = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation. Operands use it to take a magnitude
// (neg = sign bit of a signed operand). Results use it to put the sign back
// (neg = required result sign).
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    // Pass the value through, or negate it when neg is set.
    always_comb begin
        res = neg ? (~val + WIDTH'(1)) : val;
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit.
// - Multiply uses shift-add.
// - Divide uses restoring division.
// - Each operation takes WIDTH iterations, one per clock.
// - Signed operations work on magnitudes. The result sign is restored
//   while the FSM is in FINISH.
// Optional feature: define MULDIV_HILO_WRITE_EN to add the hi_we / lo_we /
// wdata ports. These allow direct writes to hi/lo (MTHI/MTLO) while the unit
// is idle.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | waiting for start; hi/lo show the last result
// S_RUN    | WIDTH iterations; cnt counts down to zero
// S_FINISH | sign-corrected result on hi/lo, done=1; a start here is accepted
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef MULDIV_HILO_WRITE_EN
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    state_e state;
    state_e state_nx;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_orig;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic [WIDTH-1:0]   hi_fin;
    logic [WIDTH-1:0]   lo_fin;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               dz_pend;
    logic               div_zero_r;

    logic               accept;
    logic               last_iter;
    logic               op_is_div;
    logic               op_signed;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     sub_diff;

    // Decode the incoming request and decide whether it is taken this cycle.
    // The FINISH cycle also accepts a start, so operations can run back to back.
    always_comb begin
        op_is_div = (op == OP_DIV) || (op == OP_DIVU);
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        sign_a    = op_signed & A[WIDTH-1];
        sign_b    = op_signed & B[WIDTH-1];
        accept    = start && ((state == S_IDLE) || (state == S_FINISH));
        last_iter = (cnt == '0);
    end

    muldiv_signfix #(.WIDTH(WIDTH)) u_mag_a (
        .val (A),
        .neg (sign_a),
        .res (a_mag)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_mag_b (
        .val (B),
        .neg (sign_b),
        .res (b_mag)
    );

    muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .val ({acc_hi, acc_lo}),
        .neg (neg_res),
        .res (prod_fix)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quo (
        .val (acc_lo),
        .neg (neg_res),
        .res (quo_fix)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (
        .val (acc_hi),
        .neg (neg_rem),
        .res (rem_fix)
    );

    // One iteration step: a conditional add for multiply and a trial
    // subtract for divide. The remainder stays below the divisor, so
    // WIDTH+1 bits are enough to hold the borrow.
    always_comb begin
        add_sum  = {1'b0, acc_hi} + {1'b0, opnd & {WIDTH{acc_lo[0]}}};
        shifted  = {acc_hi, acc_lo[WIDTH-1]};
        sub_diff = shifted - {1'b0, opnd};
    end

    // Choose the final result. Divide by zero bypasses the iteration result.
    always_comb begin
        if (dz_pend) begin
            hi_fin = a_orig;
            lo_fin = '1;
        end else if (is_div) begin
            hi_fin = rem_fix;
            lo_fin = quo_fix;
        end else begin
            hi_fin = prod_fix[2*WIDTH-1:WIDTH];
            lo_fin = prod_fix[WIDTH-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start)     state_nx = S_RUN;
            S_RUN:    if (last_iter) state_nx = S_FINISH;
            S_FINISH: state_nx = start ? S_RUN : S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // FSM outputs. During FINISH, hi/lo show the corrected result directly,
    // so the result is visible in the done cycle itself.
    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_FINISH);
        div_zero = div_zero_r;
        hi       = hi_reg;
        lo       = lo_reg;
        if (state == S_FINISH) begin
            hi = hi_fin;
            lo = lo_fin;
        end
    end

    // Iteration datapath: load operands on accept, then run one step per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            opnd       <= '0;
            a_orig     <= '0;
            is_div     <= 1'b0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            dz_pend    <= 1'b0;
            div_zero_r <= 1'b0;
        end else if (accept) begin
            cnt        <= CW'(WIDTH - 1);
            acc_hi     <= '0;
            acc_lo     <= a_mag;
            opnd       <= b_mag;
            a_orig     <= A;
            is_div     <= op_is_div;
            neg_res    <= sign_a ^ sign_b;
            neg_rem    <= sign_a;
            dz_pend    <= op_is_div && (B == '0);
            div_zero_r <= 1'b0;
        end else if (state == S_RUN) begin
            if (!last_iter) begin
                cnt <= cnt - CW'(1);
            end else begin
                div_zero_r <= dz_pend;
            end
            if (is_div) begin
                if (!sub_diff[WIDTH]) begin
                    acc_hi <= sub_diff[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi <= shifted[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_hi <= add_sum[WIDTH:1];
                acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

    // Architectural hi/lo registers.
    // - Loaded at the end of FINISH.
    // - When the write feature is enabled, also loaded by an idle-time write.
    // - A start in the same cycle wins over a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (state == S_FINISH) begin
            hi_reg <= hi_fin;
            lo_reg <= lo_fin;
        end
`ifdef MULDIV_HILO_WRITE_EN
        else if ((state == S_IDLE) && !start) begin
            if (hi_we) hi_reg <= wdata;
            if (lo_we) lo_reg <= wdata;
        end
`endif
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed, table-driven bench for mul_div_unit at WIDTH=32.
module tb_mul_div_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;
`ifdef MULDIV_HILO_WRITE_EN
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[15];

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
`ifdef MULDIV_HILO_WRITE_EN
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
`endif
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called at a negedge. Issues one start and waits for done.
    // Returns at the negedge of the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] rh, output logic [31:0] rl,
                          output logic rdz, output int busy_bad, output int hold_bad,
                          output logic [31:0] pre_hi, output logic [31:0] pre_lo);
        lat = -1; rh = '0; rl = '0; rdz = 1'b0; busy_bad = 0; hold_bad = 0;
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        pre_hi = hi;
        pre_lo = lo;
        for (int k = 1; k <= 40; k++) begin
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                lat = k; rh = hi; rl = lo; rdz = div_zero;
                break;
            end
            if (hi !== pre_hi || lo !== pre_lo) hold_bad++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, busy_bad, hold_bad, ndone, first_done;
        logic [31:0] rh, rl, ph, pl, prev_hi, prev_lo;
        logic        rdz;

        vecs[0]  = '{OP_MULT,  32'd100,        32'd200,        32'h0000_0000, 32'd20000,     1'b0};
        vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2]  = '{OP_MULTU, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4]  = '{OP_DIVU,  32'd200,        32'd100,        32'h0000_0000, 32'd2,         1'b0};
        vecs[5]  = '{OP_DIV,   32'd123,        32'd0,          32'd123,       32'hFFFF_FFFF, 1'b1};
        vecs[6]  = '{OP_MULT,  32'd2,          32'd3,          32'h0000_0000, 32'd6,         1'b0};
        vecs[7]  = '{OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[8]  = '{OP_DIVU,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{OP_DIV,   32'd7,          32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[10] = '{OP_MULT,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[11] = '{OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[12] = '{OP_DIV,   32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
        vecs[13] = '{OP_DIVU,  32'd100,        32'd7,          32'd2,         32'd14,        1'b0};
        vecs[14] = '{OP_MULT,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001, 1'b0};

        rst = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
`ifdef MULDIV_HILO_WRITE_EN
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dz", div_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        prev_hi = '0;
        prev_lo = '0;
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, rh, rl, rdz, busy_bad, hold_bad, ph, pl);
            chk($sformatf("v%0d_latency", i), lat, 33);
            chk($sformatf("v%0d_hi", i), rh, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), rl, vecs[i].lo);
            chk($sformatf("v%0d_dz", i), rdz, vecs[i].dz);
            chk($sformatf("v%0d_busy_run", i), busy_bad, 0);
            chk($sformatf("v%0d_hold_run", i), hold_bad, 0);
            chk($sformatf("v%0d_prev_lo", i), pl, prev_lo);
            chk($sformatf("v%0d_prev_hi", i), ph, prev_hi);
            @(negedge clk);
            chk($sformatf("v%0d_idle_busy", i), busy, 0);
            chk($sformatf("v%0d_idle_done", i), done, 0);
            chk($sformatf("v%0d_idle_hi", i), hi, vecs[i].hi);
            chk($sformatf("v%0d_idle_lo", i), lo, vecs[i].lo);
            chk($sformatf("v%0d_idle_dz", i), div_zero, vecs[i].dz);
            prev_hi = vecs[i].hi;
            prev_lo = vecs[i].lo;
        end

        // Back to back: the second start arrives in the done cycle of the first.
        run_op(OP_MULT, 32'd2, 32'd3, lat, rh, rl, rdz, busy_bad, hold_bad, ph, pl);
        chk("b2b_first_lo", rl, 6);
        run_op(OP_DIVU, 32'd100, 32'd7, lat, rh, rl, rdz, busy_bad, hold_bad, ph, pl);
        chk("b2b_second_latency", lat, 33);
        chk("b2b_second_pre_lo", pl, 6);
        chk("b2b_second_hi", rh, 2);
        chk("b2b_second_lo", rl, 14);
        chk("b2b_second_busy", busy_bad, 0);
        @(negedge clk);

        // A start during RUN is ignored, and only one done pulse is seen.
        start = 1'b1; op = OP_MULT; A = 32'd100; B = 32'd200;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; first_done = -1; rh = '0; rl = '0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 10) begin start = 1'b1; op = OP_DIVU; A = 32'd9; B = 32'd3; end
            if (k == 11) start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (first_done < 0) begin first_done = k; rh = hi; rl = lo; end
            end
            @(negedge clk);
        end
        chk("ignore_start_done_count", ndone, 1);
        chk("ignore_start_done_cycle", first_done, 33);
        chk("ignore_start_lo", rl, 20000);
        chk("ignore_start_hi", rh, 0);
        chk("ignore_start_idle", busy, 0);

        // A reset in the middle of a divide aborts it.
        start = 1'b1; op = OP_DIV; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k < 15; k++) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        chk("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_done", done, 0);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        chk("abort_no_done", ndone, 0);

        // When reset and start arrive together, reset wins.
        rst = 1'b1; start = 1'b1; op = OP_MULT; A = 32'd2; B = 32'd3;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_busy", busy, 0);
        @(negedge clk);
        chk("rst_prio_busy2", busy, 0);

`ifdef MULDIV_HILO_WRITE_EN
        wdata = 32'd55; lo_we = 1'b1;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_lo", lo, 55);
        chk("mtlo_hi", hi, 0);
        wdata = 32'd77; hi_we = 1'b1; start = 1'b1; op = OP_MULT; A = 32'd4; B = 32'd5;
        @(negedge clk);
        hi_we = 1'b0; start = 1'b0;
        chk("mthi_vs_start_hi", hi, 0);
        chk("mthi_vs_start_busy", busy, 1);
        ndone = 0;
        for (int k = 2; k <= 40; k++) begin
            if (k == 5) begin hi_we = 1'b1; wdata = 32'd99; end
            if (k == 6) hi_we = 1'b0;
            if (done === 1'b1) begin ndone++; rl = lo; rh = hi; end
            @(negedge clk);
        end
        chk("mthi_busy_done", ndone, 1);
        chk("mthi_busy_lo", rl, 20);
        chk("mthi_busy_hi", rh, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
